// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one registered memory port.
// Data wins contention until MAX_DATA_STREAK back-to-back data grants have starved a waiting fetch.
module mem_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ip_inst_req,
  input  logic [31:0] ip_inst_addr,
  output logic        op_inst_valid,
  output logic [31:0] op_inst_data,
  input  logic        ip_data_rd,
  input  logic        ip_data_wr,
  input  logic [31:0] ip_data_addr,
  input  logic [3:0]  ip_data_mask,
  input  logic [31:0] ip_data_wdata,
  output logic        op_data_valid,
  output logic [31:0] op_data_rdata,
  output logic [31:0] op_mem_addr,
  output logic        op_mem_rd,
  output logic        op_mem_wr,
  output logic [3:0]  op_mem_mask,
  output logic [31:0] op_mem_wdata,
  input  logic        ip_mem_valid,
  input  logic [31:0] ip_mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t     state;
  logic [3:0] streak;
  logic       data_req;
  logic       grant_d;
  logic       grant_i;

  always_comb begin
    data_req = ip_data_rd | ip_data_wr;
    grant_d  = data_req && (!ip_inst_req || (streak != STREAK_MAX));
    grant_i  = ip_inst_req && !grant_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      streak        <= '0;
      op_inst_valid <= 1'b0;
      op_inst_data  <= '0;
      op_data_valid <= 1'b0;
      op_data_rdata <= '0;
      op_mem_addr   <= '0;
      op_mem_rd     <= 1'b0;
      op_mem_wr     <= 1'b0;
      op_mem_mask   <= '0;
      op_mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state        <= BUSY_D;
            op_mem_addr  <= ip_data_addr;
            op_mem_mask  <= ip_data_mask;
            op_mem_wdata <= ip_data_wdata;
            // A simultaneous read and write is issued as the write.
            op_mem_wr    <= ip_data_wr;
            op_mem_rd    <= !ip_data_wr;
            if (!ip_inst_req)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + 4'd1;
          end else if (grant_i) begin
            state        <= BUSY_I;
            op_mem_addr  <= ip_inst_addr;
            op_mem_mask  <= 4'hF;
            op_mem_wdata <= '0;
            op_mem_rd    <= 1'b1;
            op_mem_wr    <= 1'b0;
            streak       <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (ip_mem_valid) begin
            state     <= RESP;
            op_mem_rd <= 1'b0;
            op_mem_wr <= 1'b0;
            if (state == BUSY_I) begin
              op_inst_valid <= 1'b1;
              op_inst_data  <= ip_mem_rdata;
            end else begin
              op_data_valid <= 1'b1;
              op_data_rdata <= op_mem_wr ? '0 : ip_mem_rdata;
            end
          end
        end
        RESP: begin
          state         <= IDLE;
          op_inst_valid <= 1'b0;
          op_data_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DATA_STREAK, default 4, meaning the maximum consecutive data grants while a fetch waits (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ip_inst_req, input, 1, fetch request, held until op_inst_valid is seen.
REQ-005 SHALL have port ip_inst_addr, input, 32, fetch address.
REQ-006 SHALL have port op_inst_valid, output, 1, one-cycle fetch completion pulse.
REQ-007 SHALL have port op_inst_data, output, 32, fetched word, valid with op_inst_valid.
REQ-008 SHALL have ports ip_data_rd and ip_data_wr, input, 1 each, data read/write request, held until op_data_valid is seen.
REQ-009 SHALL have ports ip_data_addr (32), ip_data_mask (4), ip_data_wdata (32), input, data address, byte enables and store data.
REQ-010 SHALL have port op_data_valid, output, 1, one-cycle data completion pulse.
REQ-011 SHALL have port op_data_rdata, output, 32, load data, valid with op_data_valid.
REQ-012 SHALL have ports op_mem_addr (32), op_mem_rd (1), op_mem_wr (1), op_mem_mask (4), op_mem_wdata (32), output, registered shared memory port.
REQ-013 SHALL have ports ip_mem_valid (1) and ip_mem_rdata (32), input, memory completion and read data.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, RESP.
REQ-015 In IDLE with a data request (ip_data_rd|ip_data_wr) and no fetch request, SHALL go to BUSY_D next edge.
REQ-016 In IDLE with only ip_inst_req, SHALL go to BUSY_I next edge.
REQ-017 In IDLE with both pending, SHALL grant data unless streak counter equals MAX_DATA_STREAK, in which case SHALL grant fetch.
REQ-018 Streak counter SHALL increment on a data grant when ip_inst_req is high, clear on a fetch grant or on a data grant with ip_inst_req low, and saturate at MAX_DATA_STREAK.
REQ-019 On grant SHALL latch the requester's address, mask, wdata and command into op_mem_* registers; fetch grant drives op_mem_rd=1, op_mem_mask=4'hF, op_mem_wr=0.
REQ-020 With ip_data_rd and ip_data_wr both high, write SHALL win; op_mem_rd=0.
REQ-021 op_mem_* SHALL stay constant throughout BUSY_I/BUSY_D regardless of requester input changes.
REQ-022 In BUSY_x on ip_mem_valid=1, SHALL go to RESP, clear op_mem_rd/op_mem_wr, and register ip_mem_rdata (zero for writes).
REQ-023 In RESP SHALL pulse exactly one of op_inst_valid/op_data_valid for one cycle with registered data, then return to IDLE.
REQ-024 Latency: request seen in IDLE at cycle 0 -> op_mem_rd/wr high cycle 1 -> ip_mem_valid at cycle k>=1 -> completion pulse cycle k+1 -> IDLE cycle k+2.
REQ-025 ip_mem_valid SHALL be ignored in IDLE and RESP.
REQ-026 op_inst_data/op_data_rdata SHALL hold their last value outside valid pulses.
REQ-027 No grant SHALL be issued while not in IDLE; requests arriving then wait.

Reset
REQ-028 reset=0 SHALL immediately force IDLE, streak counter 0, and all outputs 0, regardless of clock.
REQ-029 Reset mid-transaction SHALL abandon it; no completion pulse SHALL follow, and a late ip_mem_valid SHALL be ignored.
REQ-030 First grant SHALL occur no earlier than the first rising edge after reset returns high.

Verification
REQ-031 Fetch only: ip_inst_req=1, addr 0x100, memory valid 2 cycles after rd with 0xDEADBEEF -> op_inst_valid one cycle, op_inst_data=0xDEADBEEF, op_mem_mask=4'hF.
REQ-032 Store: ip_data_wr=1, addr 0x40, mask 4'b0011, wdata 0x1234 -> op_mem_wr=1 with those values, op_data_valid pulse, op_data_rdata=0.
REQ-033 Contention: fetch and data held continuously, MAX_DATA_STREAK=4, zero-wait memory -> grant order D,D,D,D,I then repeats.
REQ-034 rd and wr both high -> op_mem_wr=1, op_mem_rd=0.
REQ-035 Reset asserted during BUSY_D, then ip_mem_valid pulsed -> all outputs 0, no op_data_valid, state IDLE.
REQ-036 Requester changes ip_data_addr from 0x40 to 0x80 while BUSY_D -> op_mem_addr stays 0x40 until RESP.
